// File: rtl/studio2_keypad.sv
// studio2_keypad: RCA Studio II dual keypad fed from PS/2 key events.
// Holds both key-down bitmaps, the key-select latch and the EF3/EF4 flags.
module studio2_keypad (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state,
    output logic        kp_any
);

    logic        toggle_q;
    logic        evt;
    logic [9:0]  hit1;
    logic [9:0]  hit2;
    logic [9:0]  kp1_nxt;
    logic [9:0]  kp2_nxt;
    logic [3:0]  sel_nxt;
    logic [15:0] ext1;
    logic [15:0] ext2;
    logic        unused_hi;

    // The upper OUT nibble has no meaning for the keypad latch.
    assign unused_hi = ^io_dout[7:4];

    // An event is a toggle edge; extended (E0) codes never reach the keypads.
    assign evt = (ps2_key[10] ^ toggle_q) & ~ps2_key[8];

    // Map the scan code onto a one-hot digit for whichever keypad owns it.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        case (ps2_key[7:0])
            8'h45: hit1[0] = 1'b1;
            8'h16: hit1[1] = 1'b1;
            8'h1E: hit1[2] = 1'b1;
            8'h26: hit1[3] = 1'b1;
            8'h25: hit1[4] = 1'b1;
            8'h2E: hit1[5] = 1'b1;
            8'h36: hit1[6] = 1'b1;
            8'h3D: hit1[7] = 1'b1;
            8'h3E: hit1[8] = 1'b1;
            8'h46: hit1[9] = 1'b1;
            8'h70: hit2[0] = 1'b1;
            8'h69: hit2[1] = 1'b1;
            8'h72: hit2[2] = 1'b1;
            8'h7A: hit2[3] = 1'b1;
            8'h6B: hit2[4] = 1'b1;
            8'h73: hit2[5] = 1'b1;
            8'h74: hit2[6] = 1'b1;
            8'h6C: hit2[7] = 1'b1;
            8'h75: hit2[8] = 1'b1;
            8'h7D: hit2[9] = 1'b1;
            default: ;
        endcase
    end

    // Next bitmaps and select nibble; flags are derived from these so they
    // move on the same edge as the state that drives them.
    always_comb begin
        kp1_nxt = kp1_state;
        kp2_nxt = kp2_state;
        sel_nxt = key_sel;
        if (evt) begin
            if (ps2_key[9]) begin
                kp1_nxt = kp1_state | hit1;
                kp2_nxt = kp2_state | hit2;
            end else begin
                kp1_nxt = kp1_state & ~hit1;
                kp2_nxt = kp2_state & ~hit2;
            end
        end
        if (io_out && io_n == 3'b010) begin
            sel_nxt = io_dout[3:0];
        end
        // Zero-extend to 16 so selects 10..15 read a zero bit.
        ext1 = {6'b0, kp1_nxt};
        ext2 = {6'b0, kp2_nxt};
    end

    // State register; reset also resyncs toggle history to avoid a false event.
    always_ff @(posedge clk) begin
        toggle_q <= ps2_key[10];
        if (reset) begin
            kp1_state <= '0;
            kp2_state <= '0;
            key_sel   <= '0;
            ef3_n     <= 1'b1;
            ef4_n     <= 1'b1;
            kp_any    <= 1'b0;
        end else begin
            kp1_state <= kp1_nxt;
            kp2_state <= kp2_nxt;
            key_sel   <= sel_nxt;
            ef3_n     <= ~ext1[sel_nxt];
            ef4_n     <= ~ext2[sel_nxt];
            kp_any    <= |{kp1_nxt, kp2_nxt};
        end
    end

endmodule

// File: tb/tb_studio2_keypad.sv
// tb_studio2_keypad: directed and random checks of studio2_keypad
// against a table-driven keypad model.
module tb_studio2_keypad;

    logic        clk;
    logic        reset;
    logic [10:0] ps2_key;
    logic        io_out;
    logic [2:0]  io_n;
    logic [7:0]  io_dout;
    logic        ef3_n;
    logic        ef4_n;
    logic [3:0]  key_sel;
    logic [9:0]  kp1_state;
    logic [9:0]  kp2_state;
    logic        kp_any;

    studio2_keypad dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .io_out(io_out), .io_n(io_n), .io_dout(io_dout),
        .ef3_n(ef3_n), .ef4_n(ef4_n), .key_sel(key_sel),
        .kp1_state(kp1_state), .kp2_state(kp2_state), .kp_any(kp_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] codes [2][10] = '{
        '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
        '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D}
    };

    bit down [2][10];
    int sel_m;
    bit prev_t;
    bit tbit;

    function automatic logic [9:0] packed_pad(int p);
        logic [9:0] v = '0;
        for (int k = 0; k < 10; k++) v[k] = down[p][k];
        return v;
    endfunction

    function automatic bit any_down();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++)
                if (down[p][k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic e3;
        logic e4;
        e3 = !(sel_m <= 9 && down[0][sel_m]);
        e4 = !(sel_m <= 9 && down[1][sel_m]);
        chk({tag, ".kp1"}, 32'(kp1_state), 32'(packed_pad(0)));
        chk({tag, ".kp2"}, 32'(kp2_state), 32'(packed_pad(1)));
        chk({tag, ".sel"}, 32'(key_sel), 32'(sel_m));
        chk({tag, ".ef3"}, 32'(ef3_n), 32'(e3));
        chk({tag, ".ef4"}, 32'(ef4_n), 32'(e4));
        chk({tag, ".any"}, 32'(kp_any), 32'(any_down()));
    endtask

    task automatic step(string tag, bit rst, bit tog, bit pr, bit ex,
                        logic [7:0] code, bit o, logic [2:0] n,
                        logic [7:0] d);
        if (tog) tbit = ~tbit;
        reset   = rst;
        ps2_key = {tbit, pr, ex, code};
        io_out  = o;
        io_n    = n;
        io_dout = d;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 10; k++) down[p][k] = 1'b0;
            sel_m = 0;
        end else begin
            if (tbit != prev_t && !ex) begin
                for (int p = 0; p < 2; p++)
                    for (int k = 0; k < 10; k++)
                        if (codes[p][k] == code) down[p][k] = pr;
            end
            if (o && n == 3'd2) sel_m = int'(d) % 16;
        end
        prev_t = tbit;
        io_out = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(string tag);
        step(tag, 1'b0, 1'b0, ps2_key[9], ps2_key[8], ps2_key[7:0],
             1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        tbit = 1'b0;
        prev_t = 1'b0;
        sel_m = 0;
        reset = 1'b1;
        ps2_key = '0;
        io_out = 1'b0;
        io_n = '0;
        io_dout = '0;

        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
        step("rst1", 1'b1, 1'b1, 1'b1, 1'b0, 8'h2E, 1'b1, 3'd2, 8'h05);
        chk("rst.kp1", 32'(kp1_state), 32'h0);
        chk("rst.ef3", 32'(ef3_n), 32'h1);
        idle("post_rst");

        step("r24a", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h05);
        step("r24b", 1'b0, 1'b1, 1'b1, 1'b0, 8'h2E, 1'b0, 3'd0, 8'h00);
        chk("r24.kp1", 32'(kp1_state), 32'h020);
        chk("r24.ef3", 32'(ef3_n), 32'h0);
        chk("r24.ef4", 32'(ef4_n), 32'h1);
        chk("r24.any", 32'(kp_any), 32'h1);
        step("r24c", 1'b0, 1'b1, 1'b1, 1'b0, 8'h2E, 1'b0, 3'd0, 8'h00);
        chk("r24.rep", 32'(kp1_state), 32'h020);
        step("r24d", 1'b0, 1'b1, 1'b0, 1'b0, 8'h2E, 1'b0, 3'd0, 8'h00);

        step("r25a", 1'b0, 1'b1, 1'b1, 1'b0, 8'h6C, 1'b0, 3'd0, 8'h00);
        step("r25b", 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C, 1'b1, 3'd2, 8'h07);
        chk("r25.ef4a", 32'(ef4_n), 32'h0);
        step("r25c", 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C, 1'b1, 3'd2, 8'h0A);
        chk("r25.ef4b", 32'(ef4_n), 32'h1);
        step("r25d", 1'b0, 1'b0, 1'b1, 1'b0, 8'h6C, 1'b1, 3'd2, 8'hF7);
        chk("r25.sel", 32'(key_sel), 32'h7);
        chk("r25.ef4c", 32'(ef4_n), 32'h0);
        step("r25e", 1'b0, 1'b1, 1'b0, 1'b0, 8'h6C, 1'b0, 3'd0, 8'h00);

        step("r26a", 1'b0, 1'b1, 1'b1, 1'b0, 8'h16, 1'b0, 3'd0, 8'h00);
        step("r26b", 1'b0, 1'b1, 1'b1, 1'b0, 8'h69, 1'b0, 3'd0, 8'h00);
        step("r26c", 1'b0, 1'b1, 1'b0, 1'b0, 8'h16, 1'b0, 3'd0, 8'h00);
        chk("r26.kp1", 32'(kp1_state), 32'h0);
        chk("r26.kp2", 32'(kp2_state), 32'h002);
        step("r26d", 1'b0, 1'b1, 1'b0, 1'b1, 8'h69, 1'b0, 3'd0, 8'h00);
        chk("r26.ext", 32'(kp2_state), 32'h002);
        step("r26e", 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 3'd0, 8'h00);
        step("r19", 1'b0, 1'b1, 1'b0, 1'b0, 8'h45, 1'b0, 3'd0, 8'h00);

        step("r27a", 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 100; i++) idle("r27hold");
        chk("r27.kp2", 32'(kp2_state), 32'h002);
        step("r27b", 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b1, 3'd4, 8'h09);
        chk("r27.sel", 32'(key_sel), 32'h7);

        step("r28", 1'b0, 1'b1, 1'b1, 1'b0, 8'h26, 1'b1, 3'd2, 8'h03);
        chk("r28.sel", 32'(key_sel), 32'h3);
        chk("r28.ef3", 32'(ef3_n), 32'h0);

        step("r29a", 1'b1, 1'b1, 1'b1, 1'b0, 8'h46, 1'b1, 3'd2, 8'h09);
        chk("r29.kp1", 32'(kp1_state), 32'h0);
        chk("r29.any", 32'(kp_any), 32'h0);
        step("r29b", 1'b0, 1'b0, 1'b1, 1'b0, 8'h46, 1'b0, 3'd0, 8'h00);
        chk("r29.noev", 32'(kp1_state), 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) c = codes[0][$urandom_range(0, 9)];
            else if (r < 8) c = codes[1][$urandom_range(0, 9)];
            else c = 8'($urandom);
            step("rnd",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0),
                 c,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom),
                 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
